alu_operand_stage: RTL

- ID/EX pipeline register that feeds the ALU.
- Takes decoded operands from the decode stage and resolves data hazards by forwarding from the EX and MEM stages.
- Selects register, immediate or shift-amount sources and registers alu_opcode / alu_op_x / alu_op_y for the EX stage.
- Detects load-use hazards, stalls decode and inserts a bubble; honours a downstream hold and a flush.

---
 rtl/alu_operand_stage_if.sv | 40 ++++
 rtl/alu_operand_stage.sv | 129 ++++++++++++
 2 files changed

// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if
//   Decode -> operand-stage bundle: decoded instruction fields and register
//   file read data travel toward EX, de_stall travels back to decode.
//   master: decode stage (drives de_*, samples de_stall)
//   slave : alu_operand_stage (samples de_*, drives de_stall)
interface alu_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              de_valid;
  logic [4:0]        de_alu_opcode;
  logic [REG_AW-1:0] de_rs_addr;
  logic [REG_AW-1:0] de_rt_addr;
  logic [DATA_W-1:0] de_rs_data;
  logic [DATA_W-1:0] de_rt_data;
  logic [DATA_W-1:0] de_imm;
  logic [4:0]        de_shamt;
  logic              de_x_sel;
  logic              de_y_sel;
  logic              de_uses_rs;
  logic              de_uses_rt;
  logic [REG_AW-1:0] de_dest;
  logic              de_reg_we;
  logic              de_is_load;
  logic              de_stall;

  modport master (
    output de_valid, de_alu_opcode, de_rs_addr, de_rt_addr, de_rs_data,
           de_rt_data, de_imm, de_shamt, de_x_sel, de_y_sel, de_uses_rs,
           de_uses_rt, de_dest, de_reg_we, de_is_load,
    input  de_stall
  );

  modport slave (
    input  de_valid, de_alu_opcode, de_rs_addr, de_rt_addr, de_rs_data,
           de_rt_data, de_imm, de_shamt, de_x_sel, de_y_sel, de_uses_rs,
           de_uses_rt, de_dest, de_reg_we, de_is_load,
    output de_stall
  );
endinterface

// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//   ID/EX pipeline register feeding the ALU. Forwards rs/rt from EX (priority)
//   or MEM, selects register / immediate / shift-amount operands, detects
//   load-use hazards (stall decode + bubble), honours ex_hold and ex_flush.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   de                  decode bundle (alu_operand_stage_if.slave)
//   ex_result           combinational ALU result of the instruction in EX
//   ex_hold, ex_flush   downstream hold / squash
//   mem_reg_we, mem_dest, mem_result   MEM-stage writeback for forwarding
//   ex_valid, alu_opcode, alu_op_x, alu_op_y, ex_rt_data, ex_dest,
//   ex_reg_we, ex_is_load              registered EX-stage outputs
//   perf_stall_cnt, perf_fwd_cnt       performance counters
// Build option:
//   ALU_OPERAND_STAGE_PERF_EN  enables the two performance counters; when
//   undefined both counter outputs are constant 0.

`ifndef ALU_ADDU
`define ALU_ADDU 5'h00
`endif

module alu_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  alu_operand_stage_if.slave de,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_hold,
  input  logic              ex_flush,
  input  logic              mem_reg_we,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_result,
  output logic              ex_valid,
  output logic [4:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_op_x,
  output logic [DATA_W-1:0] alu_op_y,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_reg_we,
  output logic              ex_is_load,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_fwd_cnt
);

  logic              rs_ex_hit, rs_mem_hit, rt_ex_hit, rt_mem_hit;
  logic              ex_fwd_ok;
  logic [DATA_W-1:0] fwd_rs, fwd_rt, op_x, op_y;
  logic              lu, load_de;

  // A load in EX has no data yet; its consumer is caught by the load-use check.
  assign ex_fwd_ok  = ex_valid & ex_reg_we & ~ex_is_load;

  assign rs_ex_hit  = (de.de_rs_addr != '0) & ex_fwd_ok & (ex_dest == de.de_rs_addr);
  assign rs_mem_hit = (de.de_rs_addr != '0) & mem_reg_we & (mem_dest == de.de_rs_addr);
  assign rt_ex_hit  = (de.de_rt_addr != '0) & ex_fwd_ok & (ex_dest == de.de_rt_addr);
  assign rt_mem_hit = (de.de_rt_addr != '0) & mem_reg_we & (mem_dest == de.de_rt_addr);

  assign fwd_rs = rs_ex_hit ? ex_result : (rs_mem_hit ? mem_result : de.de_rs_data);
  assign fwd_rt = rt_ex_hit ? ex_result : (rt_mem_hit ? mem_result : de.de_rt_data);

  assign op_x = de.de_x_sel ? {{(DATA_W-5){1'b0}}, de.de_shamt} : fwd_rs;
  assign op_y = de.de_y_sel ? de.de_imm : fwd_rt;

  assign lu = de.de_valid & ex_valid & ex_is_load & (ex_dest != '0) &
              ((de.de_uses_rs & (ex_dest == de.de_rs_addr)) |
               (de.de_uses_rt & (ex_dest == de.de_rt_addr)));

  assign load_de     = ~ex_flush & ~ex_hold & ~lu;
  assign de.de_stall = ~ex_flush & (ex_hold | lu);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      alu_opcode <= `ALU_ADDU;
      alu_op_x   <= '0;
      alu_op_y   <= '0;
      ex_rt_data <= '0;
      ex_dest    <= '0;
      ex_reg_we  <= 1'b0;
      ex_is_load <= 1'b0;
    end else if (ex_flush || (!ex_hold && lu)) begin
      ex_valid   <= 1'b0;
      alu_opcode <= `ALU_ADDU;
      alu_op_x   <= '0;
      alu_op_y   <= '0;
      ex_rt_data <= '0;
      ex_dest    <= '0;
      ex_reg_we  <= 1'b0;
      ex_is_load <= 1'b0;
    end else if (!ex_hold) begin
      ex_valid   <= de.de_valid;
      alu_opcode <= de.de_alu_opcode;
      alu_op_x   <= op_x;
      alu_op_y   <= op_y;
      ex_rt_data <= fwd_rt;
      ex_dest    <= de.de_dest;
      ex_reg_we  <= de.de_valid & de.de_reg_we;
      ex_is_load <= de.de_valid & de.de_is_load;
    end
  end

`ifdef ALU_OPERAND_STAGE_PERF_EN
  logic       rs_fwd, rt_fwd;
  logic [1:0] fwd_n;

  // Only sources the instruction actually reads count as forwarded.
  assign rs_fwd = de.de_valid & de.de_uses_rs & (rs_ex_hit | rs_mem_hit);
  assign rt_fwd = de.de_valid & de.de_uses_rt & (rt_ex_hit | rt_mem_hit);
  assign fwd_n  = {1'b0, rs_fwd} + {1'b0, rt_fwd};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else begin
      if (lu && !ex_hold && !ex_flush)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (load_de)
        perf_fwd_cnt <= perf_fwd_cnt + {30'd0, fwd_n};
    end
  end
`else
  assign perf_stall_cnt = '0;
  assign perf_fwd_cnt   = '0;
`endif

endmodule
